// File: rtl/sync_fifo_flags_if.sv
// Handshake bundle for sync_fifo_flags: producer/consumer ports, occupancy and error flags.
// master = the side driving writes/reads; slave = the FIFO itself.
interface sync_fifo_flags_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CNT_WIDTH = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]     wdata;
  logic                 wen;
  logic                 full;
  logic                 almost_full;
  logic                 ren;
  logic [WIDTH-1:0]     rdata;
  logic                 rvalid;
  logic                 empty;
  logic                 almost_empty;
  logic [CNT_WIDTH-1:0] count;
  logic                 overflow;
  logic                 underflow;
  logic                 clr_err;

  modport master (
    output wdata, wen, ren, clr_err,
    input  full, almost_full, rdata, rvalid, empty, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wdata, wen, ren, clr_err,
    output full, almost_full, rdata, rvalid, empty, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO, arbitrary depth, occupancy count, almost flags, sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read port.
module sync_fifo_flags #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic               clk,
  input  logic               rstn,
  sync_fifo_flags_if.slave   bus
);
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_WIDTH = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_W-1:0]     wptr, rptr;
  logic [CNT_WIDTH-1:0] count;
  logic                 full, empty;
  logic                 wr_acc, rd_acc;
  logic                 ovf, udf;

  assign full   = (count == CNT_WIDTH'(DEPTH));
  assign empty  = (count == '0);
  // At full, a concurrent read frees the slot the write lands in on the same edge.
  assign rd_acc = bus.ren && !empty;
  assign wr_acc = bus.wen && (!full || bus.ren);

  // Storage is not reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rstn && wr_acc) mem[wptr] <= bus.wdata;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      // Wrap explicitly: DEPTH need not be a power of two.
      if (wr_acc) wptr <= (wptr == PTR_W'(DEPTH - 1)) ? '0 : wptr + PTR_W'(1);
      if (rd_acc) rptr <= (rptr == PTR_W'(DEPTH - 1)) ? '0 : rptr + PTR_W'(1);
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
      // Set wins over clear.
      if (bus.wen && full && !bus.ren) ovf <= 1'b1;
      else if (bus.clr_err)            ovf <= 1'b0;
      if (bus.ren && empty)            udf <= 1'b1;
      else if (bus.clr_err)            udf <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.rdata  = mem[rptr];
  assign bus.rvalid = !empty;
`else
  logic [WIDTH-1:0] rdata_q;
  logic             rvalid_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) rdata_q <= mem[rptr];
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
`endif

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count >= CNT_WIDTH'(AF_LEVEL));
  assign bus.almost_empty = (count <= CNT_WIDTH'(AE_LEVEL));
  assign bus.count        = count;
  assign bus.overflow     = ovf;
  assign bus.underflow    = udf;
endmodule
